// File: rtl/gen_primos_pkg.sv
// Shared definitions for the prime-sequence generator: FSM encoding,
// counter width and an elaboration-time integer square root.
package gen_primos_pkg;

  localparam int COUNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_SHOW   = 2'd2
  } state_t;

  // floor(sqrt(v)) for the small constant ranges used by the divisor loop
  function automatic int isqrt(input int v);
    int r;
    r = 0;
    for (int i = 0; i <= 16; i++) begin
      if (i * i <= v) begin
        r = i;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gen_primos_if.sv
// Request/result bundle between a requester (master) and the prime
// generator (slave).
interface gen_primos_if
  import gen_primos_pkg::*;
#(
  parameter int W = 4
) ();
  logic               next;
  logic               ready;
  logic               valid;
  logic [W-1:0]       prime;
  logic               wrap;
  logic [COUNT_W-1:0] count;

  modport master (output next, input ready, valid, prime, wrap, count);
  modport slave  (input next, output ready, valid, prime, wrap, count);
endinterface

// File: rtl/gen_primos_es_primo.sv
// Combinational primality test by trial division over 2..floor(sqrt(2^W-1)).
module es_primo
  import gen_primos_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] value_i,
  output logic         is_prime_o
);

  localparam int DMAX = isqrt((32'd1 << W) - 32'd1);

  // Any divisor other than the value itself rules it out; 0 and 1 never qualify
  always_comb begin
    is_prime_o = (value_i >= W'(2));
    for (int d = 2; d <= DMAX; d++) begin
      is_prime_o = is_prime_o &
                   ~((value_i != W'(d)) && ((value_i % W'(d)) == {W{1'b0}}));
    end
  end

endmodule

// File: rtl/gen_primos.sv
// Prime sequence generator: on each request, searches upward from the last
// emitted prime (mod 2^W) and presents the next prime for one cycle.
module gen_primos
  import gen_primos_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  gen_primos_if.slave  bus
);

  localparam logic [W-1:0]       ONE_W   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]       MAX_W   = {W{1'b1}};
  localparam logic [COUNT_W-1:0] ONE_CNT = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [W-1:0]       cand_q,  cand_d;
  logic [W-1:0]       prime_q, prime_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               wrap_q,  wrap_d;
  logic               cand_is_prime_s;

  es_primo #(.W(W)) u_es_primo (
    .value_i    (cand_q),
    .is_prime_o (cand_is_prime_s)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cand_q  <= {W{1'b0}};
      prime_q <= {W{1'b0}};
      count_q <= {COUNT_W{1'b0}};
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      prime_q <= prime_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state logic; count advances on entry to SHOW so it is current while valid
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    prime_d = prime_q;
    count_d = count_q;
    wrap_d  = wrap_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.next) begin
          cand_d  = prime_q + ONE_W;
          wrap_d  = (prime_q == MAX_W);
          state_d = ST_SEARCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (cand_is_prime_s) begin
          prime_d = cand_q;
          count_d = count_q + ONE_CNT;
          state_d = ST_SHOW;
        end else begin
          cand_d  = cand_q + ONE_W;
          wrap_d  = wrap_q | (cand_q == MAX_W);
          state_d = ST_SEARCH;
        end
      end
      ST_SHOW: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.ready = (state_q == ST_IDLE);
  assign bus.valid = (state_q == ST_SHOW);
  assign bus.prime = prime_q;
  assign bus.wrap  = (state_q == ST_SHOW) & wrap_q;
  assign bus.count = count_q;

endmodule

// File: tb/tb_gen_primos.sv
// Scoreboard bench for gen_primos (W=4): requests push expected results,
// a negedge monitor pops and compares whenever valid is seen.
module tb_gen_primos;
  import gen_primos_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    int prime;
    int wrap;
    int count;
    int at_cyc;
  } exp_t;
  exp_t sb_q[$];

  gen_primos_if #(.W(4)) bus ();

  gen_primos #(.W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid cycle must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("prime", int'(bus.prime), e.prime);
        chk("wrap", int'(bus.wrap), e.wrap);
        chk("count", int'(bus.count), e.count);
        chk("latency_cycle", cyc, e.at_cyc);
      end
    end
  end

  task automatic wait_ready_idle();
    int k;
    k = 0;
    while (!(bus.ready && sb_q.size() == 0) && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (k >= 60) chk("idle_timeout", 0, 1);
  endtask

  // Single-cycle request with expected result after n tested candidates
  task automatic req(input int p, input int w, input int c, input int n);
    exp_t e;
    wait_ready_idle();
    e.prime = p; e.wrap = w; e.count = c; e.at_cyc = cyc + 1 + n;
    sb_q.push_back(e);
    bus.next = 1'b1;
    @(negedge clk);
    bus.next = 1'b0;
    wait_ready_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int s;
    bus.next = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_prime", int'(bus.prime), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_wrap", int'(bus.wrap), 0);

    // First six primes, then the wrapping step 13 -> 2
    req(2, 0, 1, 2);
    req(3, 0, 2, 1);
    req(5, 0, 3, 2);
    req(7, 0, 4, 2);
    req(11, 0, 5, 4);
    req(13, 0, 6, 2);
    chk("count_after_six", int'(bus.count), 6);
    req(2, 1, 7, 5);
    req(3, 0, 8, 1);
    req(5, 0, 9, 2);
    req(7, 0, 10, 2);

    // Extra next pulse during SEARCH from 7 must be dropped
    e.prime = 11; e.wrap = 0; e.count = 11; e.at_cyc = cyc + 1 + 4;
    sb_q.push_back(e);
    bus.next = 1'b1;
    @(negedge clk);
    bus.next = 1'b0;
    @(negedge clk);
    bus.next = 1'b1;
    @(negedge clk);
    bus.next = 1'b0;
    wait_ready_idle();
    repeat (8) @(negedge clk);
    chk("count_after_ignored", int'(bus.count), 11);
    chk("prime_after_ignored", int'(bus.prime), 11);

    req(13, 0, 12, 2);

    // Reset mid-search from 13
    bus.next = 1'b1;
    @(negedge clk);
    bus.next = 1'b0;
    @(negedge clk);
    chk("searching_not_ready", int'(bus.ready), 0);
    rst = 1'b1;
    #1;
    chk("midrst_ready", int'(bus.ready), 1);
    chk("midrst_prime", int'(bus.prime), 0);
    chk("midrst_count", int'(bus.count), 0);
    chk("midrst_valid", int'(bus.valid), 0);
    @(negedge clk);
    rst = 1'b0;
    req(2, 0, 1, 2);

    // next held high: back-to-back 3, 5, 7 (one IDLE cycle between results)
    s = cyc + 1;
    e.prime = 3; e.wrap = 0; e.count = 2; e.at_cyc = s + 1; sb_q.push_back(e);
    s = s + 3;
    e.prime = 5; e.wrap = 0; e.count = 3; e.at_cyc = s + 2; sb_q.push_back(e);
    s = s + 4;
    e.prime = 7; e.wrap = 0; e.count = 4; e.at_cyc = s + 2; sb_q.push_back(e);
    bus.next = 1'b1;
    while (cyc < s + 1) @(negedge clk);
    bus.next = 1'b0;
    wait_ready_idle();
    repeat (6) @(negedge clk);
    chk("held_final_count", int'(bus.count), 4);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
